// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the pipelined ALU and its combinational core.
package alu_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ADD  = 3'd1,
    SUB  = 3'd2,
    ADDS = 3'd3,
    SUBS = 3'd4,
    AND  = 3'd5,
    OR   = 3'd6,
    XOR  = 3'd7
  } alu_op_t;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_W = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: (op, a, b) -> (result, {overflow, carry, zero}).
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2:0]        i_op,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  output logic [WIDTH-1:0]  o_result,
  output logic [FLAG_W-1:0] o_flags
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic             w_ovf_add;
  logic             w_ovf_sub;
  logic [WIDTH-1:0] w_sat;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  alu_op_t          w_op;

  assign w_op  = alu_op_t'(i_op);
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};

  assign w_ovf_add = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
  assign w_ovf_sub = (i_a[MSB] != i_b[MSB]) && (w_dif[MSB] != i_a[MSB]);

  // On overflow the true result always carries the sign of operand A.
  assign w_sat = i_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    unique case (w_op)
      NOP: w_res = '0;
      ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = w_ovf_add;
      end
      SUB: begin
        w_res   = w_dif[WIDTH-1:0];
        w_carry = w_dif[WIDTH];
        w_ovf   = w_ovf_sub;
      end
      ADDS: begin
        w_res   = w_ovf_add ? w_sat : w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = w_ovf_add;
      end
      SUBS: begin
        w_res   = w_ovf_sub ? w_sat : w_dif[WIDTH-1:0];
        w_carry = w_dif[WIDTH];
        w_ovf   = w_ovf_sub;
      end
      AND: w_res = i_a & i_b;
      OR:  w_res = i_a | i_b;
      XOR: w_res = i_a ^ i_b;
    endcase
  end

  always_comb begin
    o_result         = w_res;
    o_flags          = '0;
    o_flags[FLAG_Z]  = (w_res == '0);
    o_flags[FLAG_C]  = w_carry;
    o_flags[FLAG_V]  = w_ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: operand stage, compute stage, then delay stages, with
// bubble-collapsing valid/ready flow control and an in-order tag passthrough.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_in,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out,
  output logic [TAG_W-1:0]  tag_out,
  output logic [2:0]        flags_out
);

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] w_adv;

  logic [2:0]        r_op;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_res [1:STAGES-1];
  logic [FLAG_W-1:0] r_flg [1:STAGES-1];
  logic [TAG_W-1:0]  r_tag [0:STAGES-1];

  logic [WIDTH-1:0]  w_res;
  logic [FLAG_W-1:0] w_flg;

  // A stage may advance unless it and every stage downstream are full and the
  // consumer is stalling; written flat to avoid a self-referencing chain.
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    assign w_adv[k] = out_ready || !(&r_v[STAGES-1:k]);
  end

  assign in_ready = w_adv[0];

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_res),
    .o_flags  (w_flg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v  <= '0;
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
      for (int k = 0; k < STAGES; k++) r_tag[k] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        r_res[k] <= '0;
        r_flg[k] <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_v[0] <= in_valid;
        // Data only moves with a valid op so idle outputs keep the last result.
        if (in_valid) begin
          r_op     <= op_in;
          r_a      <= a_in;
          r_b      <= b_in;
          r_tag[0] <= tag_in;
        end
      end
      if (w_adv[1]) begin
        r_v[1] <= r_v[0];
        if (r_v[0]) begin
          r_res[1] <= w_res;
          r_flg[1] <= w_flg;
          r_tag[1] <= r_tag[0];
        end
      end
      for (int k = 2; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_v[k] <= r_v[k-1];
          if (r_v[k-1]) begin
            r_res[k] <= r_res[k-1];
            r_flg[k] <= r_flg[k-1];
            r_tag[k] <= r_tag[k-1];
          end
        end
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign out       = r_res[STAGES-1];
  assign flags_out = r_flg[STAGES-1];
  assign tag_out   = r_tag[STAGES-1];

endmodule
